// File: rtl/cntr_modn_pkg.sv
// Shared definitions for the modulo-N counter: end-of-range modes and default geometry.
package cntr_modn_pkg;

  localparam bit CNTR_WRAP        = 1'b0;
  localparam bit CNTR_SAT         = 1'b1;
  localparam int CNTR_DEF_WIDTH   = 32'sd4;
  localparam int CNTR_DEF_MODULUS = 32'sd10;

endpackage

// File: rtl/cntr_modn_if.sv
// Request/status bundle of the modulo-N counter; master drives requests, slave is the counter.
interface cntr_modn_if
  import cntr_modn_pkg::*;
#(
  parameter int WIDTH = CNTR_DEF_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             at_max;
  logic             at_min;
  logic             err;

  modport master (
    output load, load_val, inc, dec,
    input  cnt, wrap, at_max, at_min, err
  );

  modport slave (
    input  load, load_val, inc, dec,
    output cnt, wrap, at_max, at_min, err
  );

endinterface

// File: rtl/cntr_modn_dff_r_sync.sv
// WIDTH-bit register with synchronous active-low reset to zero.
module cntr_modn_dff_r_sync #(
  parameter int WIDTH = 32'sd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // State register; reset takes precedence over the incoming data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/cntr_modn.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate ends and sticky load-error flag.
module cntr_modn
  import cntr_modn_pkg::*;
#(
  parameter int WIDTH    = CNTR_DEF_WIDTH,
  parameter int MODULUS  = CNTR_DEF_MODULUS,
  parameter bit SATURATE = CNTR_WRAP
) (
  input  logic        clk,
  input  logic        reset_n,
  cntr_modn_if.slave  bus
);

  localparam int MOD_LIMIT = 32'sd1 << WIDTH;

  if ((MODULUS < 32'sd2) || (MODULUS > MOD_LIMIT)) begin : g_bad_modulus
    $error("cntr_modn: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // Comparisons run one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 32'sd1);

  logic [WIDTH-1:0] cnt_r;
  logic             wrap_r;
  logic             err_r;
  logic [WIDTH-1:0] next_cnt_s;
  logic             next_wrap_s;
  logic             next_err_s;
  logic [WIDTH:0]   sum_s;
  logic             load_ok_s;

  assign sum_s     = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
  assign load_ok_s = ({1'b0, bus.load_val} < MOD_EXT);

  // Next-state: load beats inc/dec; inc and dec together hold.
  always_comb begin
    next_cnt_s  = cnt_r;
    next_wrap_s = 1'b0;
    next_err_s  = err_r;
    if (bus.load) begin
      if (load_ok_s) begin
        next_cnt_s = bus.load_val;
        next_err_s = 1'b0;
      end else begin
        next_err_s = 1'b1;
      end
    end else if (bus.inc && !bus.dec) begin
      if (sum_s < MOD_EXT) begin
        next_cnt_s = sum_s[WIDTH-1:0];
      end else begin
        next_wrap_s = 1'b1;
        if (SATURATE == CNTR_SAT) begin
          next_cnt_s = cnt_r;
        end else begin
          next_cnt_s = '0;
        end
      end
    end else if (bus.dec && !bus.inc) begin
      if (cnt_r != '0) begin
        next_cnt_s = cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        next_wrap_s = 1'b1;
        if (SATURATE == CNTR_SAT) begin
          next_cnt_s = cnt_r;
        end else begin
          next_cnt_s = MAX_VAL;
        end
      end
    end else begin
      next_cnt_s = cnt_r;
    end
  end

  cntr_modn_dff_r_sync #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (next_cnt_s),
    .q       (cnt_r)
  );

  cntr_modn_dff_r_sync #(.WIDTH(32'sd1)) u_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (next_wrap_s),
    .q       (wrap_r)
  );

  cntr_modn_dff_r_sync #(.WIDTH(32'sd1)) u_err (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (next_err_s),
    .q       (err_r)
  );

  assign bus.cnt    = cnt_r;
  assign bus.wrap   = wrap_r;
  assign bus.err    = err_r;
  assign bus.at_max = (cnt_r == MAX_VAL);
  assign bus.at_min = (cnt_r == '0);

endmodule

// File: tb/tb_cntr_modn.sv
// Directed bench for cntr_modn across wrap, saturate, MODULUS=3 and MODULUS=2**WIDTH configurations.
module tb_cntr_modn;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  cntr_modn_if #(.WIDTH(4)) if_a ();
  cntr_modn_if #(.WIDTH(4)) if_b ();
  cntr_modn_if #(.WIDTH(2)) if_c ();
  cntr_modn_if #(.WIDTH(4)) if_d ();

  cntr_modn #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  cntr_modn #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  cntr_modn #(.WIDTH(2), .MODULUS(3),  .SATURATE(1'b0)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c.slave));
  cntr_modn #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_d (.clk(clk), .reset_n(reset_n), .bus(if_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    if_a.load = 1'b0; if_a.load_val = 4'd0; if_a.inc = 1'b0; if_a.dec = 1'b0;
    if_b.load = 1'b0; if_b.load_val = 4'd0; if_b.inc = 1'b0; if_b.dec = 1'b0;
    if_c.load = 1'b0; if_c.load_val = 2'd0; if_c.inc = 1'b0; if_c.dec = 1'b0;
    if_d.load = 1'b0; if_d.load_val = 4'd0; if_d.inc = 1'b0; if_d.dec = 1'b0;

    // Reset for two cycles, then idle.
    step(); step();
    check("rst_cnt", if_a.cnt, 0);
    check("rst_at_min", if_a.at_min, 1);
    check("rst_at_max", if_a.at_max, 0);
    check("rst_wrap", if_a.wrap, 0);
    check("rst_err", if_a.err, 0);
    reset_n = 1'b1;
    step(); step();
    check("hold_cnt", if_a.cnt, 0);
    check("hold_at_min", if_a.at_min, 1);
    check("hold_wrap", if_a.wrap, 0);
    check("hold_err", if_a.err, 0);
    check("hold_b_cnt", if_b.cnt, 0);

    // Upward wrap over ten edges.
    if_a.inc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("up_cnt_%0d", i), if_a.cnt, i % 10);
      check($sformatf("up_wrap_%0d", i), if_a.wrap, (i == 10) ? 1 : 0);
      check($sformatf("up_at_max_%0d", i), if_a.at_max, (i == 9) ? 1 : 0);
    end
    if_a.inc = 1'b0;

    // Downward wrap from zero.
    if_a.dec = 1'b1;
    step();
    check("dn_wrap_cnt", if_a.cnt, 9);
    check("dn_wrap_pulse", if_a.wrap, 1);
    check("dn_wrap_at_max", if_a.at_max, 1);
    if_a.dec = 1'b0;
    step();
    check("dn_wrap_hold_cnt", if_a.cnt, 9);
    check("dn_wrap_pulse_end", if_a.wrap, 0);

    // Saturating down at zero, held for two edges.
    if_b.dec = 1'b1;
    step();
    check("sat_cnt", if_b.cnt, 0);
    check("sat_wrap", if_b.wrap, 1);
    step();
    check("sat_cnt2", if_b.cnt, 0);
    check("sat_wrap2", if_b.wrap, 1);
    if_b.dec = 1'b0;
    step();
    check("sat_wrap_end", if_b.wrap, 0);

    // Load sequence: 7, bad 12, inc, 3.
    if_a.load = 1'b1; if_a.load_val = 4'd7;
    step();
    check("ld7_cnt", if_a.cnt, 7);
    check("ld7_err", if_a.err, 0);
    if_a.load_val = 4'd12;
    step();
    check("ld12_cnt", if_a.cnt, 7);
    check("ld12_err", if_a.err, 1);
    check("ld12_wrap", if_a.wrap, 0);
    if_a.load = 1'b0; if_a.inc = 1'b1;
    step();
    check("ldinc_cnt", if_a.cnt, 8);
    check("ldinc_err", if_a.err, 1);
    if_a.inc = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd3;
    step();
    check("ld3_cnt", if_a.cnt, 3);
    check("ld3_err", if_a.err, 0);
    if_a.load = 1'b0;

    // MODULUS=3 with inc held.
    if_c.inc = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("m3_cnt_%0d", i), if_c.cnt, i % 3);
      check($sformatf("m3_wrap_%0d", i), if_c.wrap, ((i % 3) == 0) ? 1 : 0);
    end
    if_c.inc = 1'b0;

    // MODULUS=16 (full range) with inc held.
    if_d.inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("m16_cnt_%0d", i), if_d.cnt, i % 16);
      check($sformatf("m16_wrap_%0d", i), if_d.wrap, (i == 16) ? 1 : 0);
    end
    check("m16_at_min", if_d.at_min, 1);
    if_d.inc = 1'b0;
    if_d.load = 1'b1; if_d.load_val = 4'd15;
    step();
    check("m16_ld15_cnt", if_d.cnt, 15);
    check("m16_ld15_err", if_d.err, 0);
    check("m16_at_max", if_d.at_max, 1);
    if_d.load = 1'b0;

    // Priority: load over inc, inc+dec holds, then reset mid-count.
    if_a.load = 1'b1; if_a.inc = 1'b1; if_a.load_val = 4'd5;
    step();
    check("pri_load_cnt", if_a.cnt, 5);
    if_a.load = 1'b0; if_a.dec = 1'b1;
    step();
    check("pri_both_cnt", if_a.cnt, 5);
    check("pri_both_wrap", if_a.wrap, 0);
    if_a.dec = 1'b0;
    step();
    check("pri_inc_cnt", if_a.cnt, 6);
    if_a.inc = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd10;
    step();
    check("bad10_cnt", if_a.cnt, 6);
    check("bad10_err", if_a.err, 1);
    if_a.load = 1'b0; if_a.inc = 1'b1; reset_n = 1'b0;
    step();
    check("midrst_cnt", if_a.cnt, 0);
    check("midrst_err", if_a.err, 0);
    check("midrst_wrap", if_a.wrap, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_cnt", if_a.cnt, 1);
    if_a.inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
